// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory handshake, redirect input and the
// instruction slot handed to the IF/ID latch.
interface instr_fetch_unit_if #(
    parameter int unsigned PC_WIDTH    = 16,
    parameter int unsigned INSTR_WIDTH = 32
);
    logic                   stall;
    logic                   redirect;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ready;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    instr_pc;
    logic                   instr_valid;

    modport master (
        input  stall, redirect, redirect_pc, imem_ready, imem_rdata,
        output imem_req, imem_addr, instr, instr_pc, instr_valid
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_ready, imem_rdata,
        input  imem_req, imem_addr, instr, instr_pc, instr_valid
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding imem request,
// output slot plus one-entry skid so a stalled completion is never lost.
module instr_fetch_unit #(
    parameter int unsigned         PC_WIDTH    = 16,
    parameter int unsigned         INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input logic                clk,
    input logic                reset,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {
        S_REQ,
        S_HOLD,
        S_DROP
    } state_e;

    localparam logic [PC_WIDTH-1:0] PC_ONE = 1;

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    pending_pc_q, pending_pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    instr_pc_q, instr_pc_d;
    logic                   instr_valid_q, instr_valid_d;
    logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [PC_WIDTH-1:0]    skid_pc_q, skid_pc_d;
    logic                   skid_valid_q, skid_valid_d;

    logic req;
    logic done;
    logic can_load;

    assign req      = (state_q == S_REQ || state_q == S_DROP) && !reset;
    assign done     = req && bus.imem_ready;
    assign can_load = !instr_valid_q || !bus.stall;

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pending_pc_d  = pending_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        // A consumed slot empties unless something below refills it.
        instr_valid_d = instr_valid_q && bus.stall;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        skid_valid_d  = skid_valid_q;

        if (bus.redirect) begin
            instr_valid_d = 1'b0;
            skid_valid_d  = 1'b0;
        end

        unique case (state_q)
            S_REQ: begin
                if (bus.redirect) begin
                    if (done) begin
                        pc_d = bus.redirect_pc;
                    end else begin
                        pending_pc_d = bus.redirect_pc;
                        state_d      = S_DROP;
                    end
                end else if (done) begin
                    pc_d = pc_q + PC_ONE;
                    if (can_load) begin
                        instr_d       = bus.imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                    end else begin
                        skid_instr_d = bus.imem_rdata;
                        skid_pc_d    = pc_q;
                        skid_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.redirect) begin
                    pc_d    = bus.redirect_pc;
                    state_d = S_REQ;
                end else if (!bus.stall) begin
                    instr_d       = skid_instr_q;
                    instr_pc_d    = skid_pc_q;
                    instr_valid_d = 1'b1;
                    skid_valid_d  = 1'b0;
                    state_d       = S_REQ;
                end
            end
            S_DROP: begin
                if (bus.redirect) begin
                    pending_pc_d = bus.redirect_pc;
                end
                // A redirect landing on the completing edge is the newest target.
                if (done) begin
                    pc_d    = bus.redirect ? bus.redirect_pc : pending_pc_q;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            pending_pc_q  <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
            skid_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pending_pc_q  <= pending_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            skid_valid_q  <= skid_valid_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: queue-based reference model feeds
// expected bus cycles and deliveries; negedge monitors compare against the DUT.
module tb_instr_fetch_unit;
    logic clk;
    logic rst;
    logic wrst;
    logic wchk;

    int n_cmp;
    int n_err;

    instr_fetch_unit_if #(.PC_WIDTH(16), .INSTR_WIDTH(32)) bus ();
    instr_fetch_unit_if #(.PC_WIDTH(16), .INSTR_WIDTH(32)) wbus ();

    instr_fetch_unit #(.PC_WIDTH(16), .INSTR_WIDTH(32), .RESET_PC(16'h0000)) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    instr_fetch_unit #(.PC_WIDTH(16), .INSTR_WIDTH(32), .RESET_PC(16'hFFFE)) u_wrap (
        .clk   (clk),
        .reset (wrst),
        .bus   (wbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [15:0] a);
        return {a ^ 16'hC3A5, a};
    endfunction

    assign wbus.stall       = 1'b0;
    assign wbus.redirect    = 1'b0;
    assign wbus.redirect_pc = 16'h0000;
    assign wbus.imem_ready  = 1'b1;
    assign wbus.imem_rdata  = mem(wbus.imem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered instructions held as a queue (head = output slot).
    typedef struct packed {
        logic        req;
        logic [15:0] addr;
        logic        valid;
    } cyc_t;

    cyc_t        cyc_q[$];
    logic [47:0] dlv_q[$];
    logic [47:0] wexp_q[$];
    logic [47:0] buf_q[$];
    logic [15:0] m_pc;
    logic [15:0] m_pend;
    int          m_mode;  // 0 fetching, 1 holding (skid full), 2 dropping
    bit          armed;

    task automatic step(input logic r, input logic st, input logic rdy,
                        input logic rd, input logic [15:0] rpc);
        cyc_t c;
        @(posedge clk);
        #1;
        rst             = r;
        bus.stall       = st;
        bus.imem_ready  = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.imem_rdata  = mem(bus.imem_addr);
        if (armed) begin
            c.req   = !r && (m_mode != 1);
            c.addr  = m_pc;
            c.valid = (buf_q.size() > 0);
            cyc_q.push_back(c);
            if (buf_q.size() > 0 && !st) dlv_q.push_back(buf_q[0]);
        end
        if (r) begin
            buf_q.delete();
            m_pc   = 16'h0000;
            m_mode = 0;
            armed  = 1'b1;
        end else begin
            if (buf_q.size() > 0 && !st) void'(buf_q.pop_front());
            if (rd) begin
                buf_q.delete();
                case (m_mode)
                    0: if (rdy) m_pc = rpc; else begin m_pend = rpc; m_mode = 2; end
                    1: begin m_pc = rpc; m_mode = 0; end
                    default: if (rdy) begin m_pc = rpc; m_mode = 0; end else m_pend = rpc;
                endcase
            end else begin
                case (m_mode)
                    0: if (rdy) begin
                        buf_q.push_back({mem(m_pc), m_pc});
                        m_pc = m_pc + 16'd1;
                        if (buf_q.size() == 2) m_mode = 1;
                    end
                    1: if (buf_q.size() == 1) m_mode = 0;
                    default: if (rdy) begin m_pc = m_pend; m_mode = 0; end
                endcase
            end
        end
    endtask

    always @(negedge clk) begin
        cyc_t c;
        logic [47:0] e;
        if (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            check("imem_req", 64'(bus.imem_req), 64'(c.req));
            if (c.req) check("imem_addr", 64'(bus.imem_addr), 64'(c.addr));
            check("instr_valid", 64'(bus.instr_valid), 64'(c.valid));
            if (bus.instr_valid === 1'b1 && bus.stall === 1'b0) begin
                if (dlv_q.size() == 0) begin
                    check("unexpected_delivery_pc", 64'(bus.instr_pc), 64'hDEAD_0000_0000);
                end else begin
                    e = dlv_q.pop_front();
                    check("deliver_pc", 64'(bus.instr_pc), 64'(e[15:0]));
                    check("deliver_instr", 64'(bus.instr), 64'(e[47:16]));
                end
            end
        end
        if (wchk && wbus.instr_valid === 1'b1 && wexp_q.size() > 0) begin
            e = wexp_q.pop_front();
            check("wrap_pc", 64'(wbus.instr_pc), 64'(e[15:0]));
            check("wrap_instr", 64'(wbus.instr), 64'(e[47:16]));
        end
    end

    initial begin
        logic [15:0] p;
        wrst = 1'b1;
        wchk = 1'b0;
        p = 16'hFFFE;
        for (int unsigned i = 0; i < 4; i++) begin
            wexp_q.push_back({mem(p), p});
            p = p + 16'd1;
        end
        repeat (2) @(posedge clk);
        #1;
        wrst = 1'b0;
        wchk = 1'b1;
    end

    initial begin
        logic        r, st, rdy, rd;
        logic [15:0] rpc;
        n_cmp = 0;
        n_err = 0;
        armed = 1'b0;
        m_pc = '0;
        m_pend = '0;
        m_mode = 0;
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.imem_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_rdata = '0;

        repeat (2) step(1, 0, 0, 0, 16'h0);
        repeat (8) step(0, 0, 1, 0, 16'h0);
        repeat (3) step(0, 1, 1, 0, 16'h0);
        repeat (3) step(0, 0, 1, 0, 16'h0);
        step(0, 0, 0, 0, 16'h0);
        step(0, 0, 0, 1, 16'h0040);
        repeat (2) step(0, 0, 0, 0, 16'h0);
        repeat (4) step(0, 0, 1, 0, 16'h0);
        step(0, 0, 1, 1, 16'h0100);
        repeat (3) step(0, 0, 1, 0, 16'h0);
        step(0, 0, 0, 1, 16'h0222);
        step(0, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        repeat (4) step(0, 0, 1, 0, 16'h0);
        step(0, 0, 1, 1, 16'hFFFD);
        repeat (5) step(0, 0, 1, 0, 16'h0);

        for (int unsigned i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            st  = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 1) == 0) ? 16'($urandom) : (16'hFFF8 + 16'($urandom_range(0, 7)));
            step(r, st, rdy, rd, rpc);
        end
        repeat (3) step(0, 0, 1, 0, 16'h0);

        @(negedge clk);
        #1;
        check("delivery_queue_drained", 64'(dlv_q.size()), 64'd0);
        check("wrap_queue_drained", 64'(wexp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
